shot_scheduler: RTL and testbench

//  Two-player game controller that shares one trajectory calculator between two players.
//  - Arbitrates the players' shot requests and latches the granted player's aim.
//  - Issues a one-cycle shoot pulse to the calculator and waits for its result.
//  - Keeps per-player scores and declares a winner at WIN_SCORE.
//  - Sits between the player input decoders and the trajectory calculator.

---
 rtl/shot_scheduler_if.sv | 38 +++
 rtl/shot_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_shot_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/shot_scheduler_if.sv
// Player/calculator signal bundle for the shot scheduler.
// The master side drives requests, aims and calculator results; the slave side is the scheduler.
interface shot_scheduler_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start;
  logic               p0_req;
  logic               p1_req;
  logic [15:0]        p0_aim;
  logic [15:0]        p1_aim;
  logic               p0_grant;
  logic               p1_grant;
  logic               calc_shoot;
  logic [4:0]         calc_x_pos;
  logic [4:0]         calc_rise;
  logic [4:0]         calc_run;
  logic               calc_dir;
  logic               calc_valid;
  logic               calc_hit;
  logic [SCORE_W-1:0] p0_score;
  logic [SCORE_W-1:0] p1_score;
  logic               busy;
  logic               game_over;
  logic               winner;
  logic               timeout_err;

  modport master (
    output start, p0_req, p1_req, p0_aim, p1_aim, calc_valid, calc_hit,
    input  p0_grant, p1_grant, calc_shoot, calc_x_pos, calc_rise, calc_run, calc_dir,
    input  p0_score, p1_score, busy, game_over, winner, timeout_err
  );

  modport slave (
    input  start, p0_req, p1_req, p0_aim, p1_aim, calc_valid, calc_hit,
    output p0_grant, p1_grant, calc_shoot, calc_x_pos, calc_rise, calc_run, calc_dir,
    output p0_score, p1_score, busy, game_over, winner, timeout_err
  );
endinterface

// File: rtl/shot_scheduler.sv
// Two-player game controller sharing one trajectory calculator.
// Arbitrates shots round-robin, issues a shoot pulse, scores results and declares a winner.
module shot_scheduler #(
  parameter int unsigned WIN_SCORE = 3,
  parameter int unsigned SCORE_W   = 4,
  parameter int unsigned TIMEOUT   = 63
) (
  input logic             clk,
  input logic             rst_n,
  shot_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, ISSUE, WAIT_RES, SCORE, OVER
  } state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               shooter_q, shooter_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               p0_grant_q, p0_grant_d;
  logic               p1_grant_q, p1_grant_d;
  logic               shoot_q, shoot_d;
  logic [4:0]         x_pos_q, x_pos_d;
  logic [4:0]         rise_q, rise_d;
  logic [4:0]         run_q, run_d;
  logic               dir_q, dir_d;
  logic [SCORE_W-1:0] p0_score_q, p0_score_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic               busy_q, busy_d;
  logic               over_q, over_d;
  logic               winner_q, winner_d;
  logic               terr_q, terr_d;

  logic               restart;
  logic               pick;
  logic [15:0]        aim;
  logic [SCORE_W-1:0] shooter_score;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      shooter_q  <= 1'b0;
      cnt_q      <= '0;
      p0_grant_q <= 1'b0;
      p1_grant_q <= 1'b0;
      shoot_q    <= 1'b0;
      x_pos_q    <= '0;
      rise_q     <= '0;
      run_q      <= '0;
      dir_q      <= 1'b0;
      p0_score_q <= '0;
      p1_score_q <= '0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
      winner_q   <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      shooter_q  <= shooter_d;
      cnt_q      <= cnt_d;
      p0_grant_q <= p0_grant_d;
      p1_grant_q <= p1_grant_d;
      shoot_q    <= shoot_d;
      x_pos_q    <= x_pos_d;
      rise_q     <= rise_d;
      run_q      <= run_d;
      dir_q      <= dir_d;
      p0_score_q <= p0_score_d;
      p1_score_q <= p1_score_d;
      busy_q     <= busy_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
      terr_q     <= terr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    shooter_d     = shooter_q;
    cnt_d         = cnt_q;
    p0_grant_d    = 1'b0;
    p1_grant_d    = 1'b0;
    shoot_d       = 1'b0;
    x_pos_d       = x_pos_q;
    rise_d        = rise_q;
    run_d         = run_q;
    dir_d         = dir_q;
    p0_score_d    = p0_score_q;
    p1_score_d    = p1_score_q;
    winner_d      = winner_q;
    terr_d        = terr_q;
    restart       = 1'b0;
    pick          = 1'b0;
    aim           = bus.p0_aim;
    shooter_score = shooter_q ? p1_score_q : p0_score_q;

    case (state_q)
      IDLE: restart = bus.start;
      WAIT_REQ: begin
        if (bus.start) begin
          restart = 1'b1;
        end else if (bus.p0_req || bus.p1_req) begin
          // A lone requester wins outright; a tie goes to the priority holder
          pick       = (bus.p0_req && bus.p1_req) ? prio_q : bus.p1_req;
          aim        = pick ? bus.p1_aim : bus.p0_aim;
          p0_grant_d = ~pick;
          p1_grant_d = pick;
          dir_d      = aim[15];
          x_pos_d    = aim[14:10];
          rise_d     = aim[9:5];
          run_d      = aim[4:0];
          shooter_d  = pick;
          prio_d     = ~pick;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        shoot_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        // Score lands with the transition so it is visible one cycle after calc_valid
        if (bus.calc_valid) begin
          if (bus.calc_hit) begin
            if (shooter_score != {SCORE_W{1'b1}}) begin
              if (shooter_q) p1_score_d = p1_score_q + SCORE_W'(1);
              else           p0_score_d = p0_score_q + SCORE_W'(1);
            end
          end
          state_d = SCORE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = WAIT_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCORE: begin
        if (shooter_score >= SCORE_W'(WIN_SCORE)) begin
          winner_d = shooter_q;
          state_d  = OVER;
        end else begin
          state_d = WAIT_REQ;
        end
      end
      OVER: restart = bus.start;
      default: state_d = IDLE;
    endcase

    if (restart) begin
      p0_score_d = '0;
      p1_score_d = '0;
      terr_d     = 1'b0;
      prio_d     = 1'b0;
      winner_d   = 1'b0;
      state_d    = WAIT_REQ;
    end

    busy_d = (state_d == ISSUE) || (state_d == WAIT_RES) || (state_d == SCORE);
    over_d = (state_d == OVER);
  end

  assign bus.p0_grant    = p0_grant_q;
  assign bus.p1_grant    = p1_grant_q;
  assign bus.calc_shoot  = shoot_q;
  assign bus.calc_x_pos  = x_pos_q;
  assign bus.calc_rise   = rise_q;
  assign bus.calc_run    = run_q;
  assign bus.calc_dir    = dir_q;
  assign bus.p0_score    = p0_score_q;
  assign bus.p1_score    = p1_score_q;
  assign bus.busy        = busy_q;
  assign bus.game_over   = over_q;
  assign bus.winner      = winner_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler: arbitration, shoot timing, scoring, timeout and reset.
module tb_shot_scheduler;

  localparam int unsigned TO = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  shot_scheduler_if #(.SCORE_W(4)) bus ();

  shot_scheduler #(.WIN_SCORE(3), .SCORE_W(4), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.p0_grant, bus.p1_grant, bus.calc_shoot, bus.calc_x_pos, bus.calc_rise,
                bus.calc_run, bus.calc_dir, bus.p0_score, bus.p1_score, bus.busy,
                bus.game_over, bus.winner, bus.timeout_err});
  endfunction

  // One full shot from the grant edge; calc_valid returned in the third cycle after the shoot
  task automatic do_shot(input int who, input logic hit, input int exp_p0, input int exp_p1);
    int extra = 0;
    tick;
    chk("grant_p0", 32'(bus.p0_grant), 32'(who == 0));
    chk("grant_p1", 32'(bus.p1_grant), 32'(who == 1));
    chk("no_shoot_at_grant", 32'(bus.calc_shoot), 0);
    tick;
    chk("shoot_pulse", 32'(bus.calc_shoot), 1);
    repeat (3) begin
      tick;
      extra += int'(bus.calc_shoot) + int'(bus.p0_grant) + int'(bus.p1_grant);
    end
    chk("extra_pulses", 32'(extra), 0);
    bus.calc_valid = 1'b1;
    bus.calc_hit   = hit;
    tick;
    bus.calc_valid = 1'b0;
    bus.calc_hit   = 1'b0;
    chk("p0_score", 32'(bus.p0_score), 32'(exp_p0));
    chk("p1_score", 32'(bus.p1_score), 32'(exp_p1));
    tick;
  endtask

  initial begin
    int extra;
    bus.start = 1'b0;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    bus.p0_aim = 16'h0000;
    bus.p1_aim = 16'h7E29;
    bus.calc_valid = 1'b0;
    bus.calc_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    tick;

    // Grant, then shoot one cycle later carrying the latched aim
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.p0_req = 1'b1;
    bus.p0_aim = 16'h9081;
    tick;
    bus.p0_req = 1'b0;
    bus.p0_aim = 16'h0000;
    chk("t1_grant_p0", 32'(bus.p0_grant), 1);
    chk("t1_grant_p1", 32'(bus.p1_grant), 0);
    chk("t1_shoot_early", 32'(bus.calc_shoot), 0);
    chk("t1_aim", 32'({bus.calc_dir, bus.calc_x_pos, bus.calc_rise, bus.calc_run}), 32'h9081);
    chk("t1_busy", 32'(bus.busy), 1);
    tick;
    chk("t1_shoot", 32'(bus.calc_shoot), 1);
    chk("t1_grant_gone", 32'(bus.p0_grant), 0);
    chk("t1_aim_held", 32'({bus.calc_dir, bus.calc_x_pos, bus.calc_rise, bus.calc_run}), 32'h9081);
    tick;
    chk("t1_shoot_one_cycle", 32'(bus.calc_shoot), 0);
    bus.calc_valid = 1'b1;
    tick;
    bus.calc_valid = 1'b0;
    chk("t1_miss_scores", 32'({bus.p0_score, bus.p1_score}), 0);
    tick;
    chk("t1_idle_busy", 32'(bus.busy), 0);

    // Both requesting: round-robin p0,p1,p0,p1 after a restart
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.p0_req = 1'b1;
    bus.p1_req = 1'b1;
    do_shot(0, 1'b0, 0, 0);
    do_shot(1, 1'b0, 0, 0);
    do_shot(0, 1'b0, 0, 0);
    do_shot(1, 1'b0, 0, 0);

    // p1 hits three times and wins
    bus.p0_req = 1'b0;
    do_shot(1, 1'b1, 0, 1);
    chk("t3_p1_aim", 32'({bus.calc_dir, bus.calc_x_pos, bus.calc_rise, bus.calc_run}), 32'h7E29);
    do_shot(1, 1'b1, 0, 2);
    do_shot(1, 1'b1, 0, 3);
    chk("t3_game_over", 32'(bus.game_over), 1);
    chk("t3_winner", 32'(bus.winner), 1);
    chk("t3_busy", 32'(bus.busy), 0);
    bus.p0_req = 1'b1;
    extra = 0;
    repeat (5) begin
      tick;
      extra += int'(bus.p0_grant) + int'(bus.p1_grant) + int'(bus.calc_shoot);
    end
    chk("t3_no_grant_over", 32'(extra), 0);
    chk("t3_still_over", 32'(bus.game_over), 1);

    // Restart from OVER
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("t6_scores_cleared", 32'({bus.p0_score, bus.p1_score}), 0);
    chk("t6_over_cleared", 32'(bus.game_over), 0);
    chk("t6_winner_cleared", 32'(bus.winner), 0);

    // No result: abort after TIMEOUT cycles
    bus.p0_req = 1'b1;
    tick;
    bus.p0_req = 1'b0;
    tick;
    chk("t4_shoot", 32'(bus.calc_shoot), 1);
    repeat (TO - 1) tick;
    chk("t4_not_yet", 32'(bus.timeout_err), 0);
    chk("t4_busy_waiting", 32'(bus.busy), 1);
    tick;
    chk("t4_timeout", 32'(bus.timeout_err), 1);
    chk("t4_back_wait_req", 32'(bus.busy), 0);
    chk("t4_scores", 32'({bus.p0_score, bus.p1_score}), 0);

    // Restart clears timeout_err; result on the expiry cycle is scored
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("t4_terr_cleared", 32'(bus.timeout_err), 0);
    bus.p1_req = 1'b1;
    tick;
    bus.p1_req = 1'b0;
    chk("t4b_grant_p1", 32'(bus.p1_grant), 1);
    tick;
    repeat (TO - 1) tick;
    bus.calc_valid = 1'b1;
    bus.calc_hit = 1'b1;
    tick;
    bus.calc_valid = 1'b0;
    bus.calc_hit = 1'b0;
    chk("t4b_scored", 32'(bus.p1_score), 1);
    chk("t4b_no_timeout", 32'(bus.timeout_err), 0);
    chk("t4b_busy_score", 32'(bus.busy), 1);
    tick;
    chk("t4b_idle", 32'(bus.busy), 0);

    // start during WAIT_RES is ignored
    bus.p0_req = 1'b1;
    tick;
    bus.p0_req = 1'b0;
    tick;
    bus.start = 1'b1;
    repeat (2) tick;
    bus.start = 1'b0;
    chk("t6a_busy", 32'(bus.busy), 1);
    chk("t6a_p1_kept", 32'(bus.p1_score), 1);
    bus.calc_valid = 1'b1;
    bus.calc_hit = 1'b1;
    tick;
    bus.calc_valid = 1'b0;
    bus.calc_hit = 1'b0;
    chk("t6a_p0_scored", 32'(bus.p0_score), 1);
    tick;

    // Reset while the shoot pulse is high
    bus.p1_req = 1'b1;
    tick;
    bus.p1_req = 1'b0;
    tick;
    chk("t5_shoot", 32'(bus.calc_shoot), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", outs(), 0);
    bus.calc_valid = 1'b1;
    bus.calc_hit = 1'b1;
    bus.p0_req = 1'b1;
    #3;
    rst_n = 1'b1;
    repeat (3) tick;
    chk("t5_idle_ignores", outs(), 0);
    bus.calc_valid = 1'b0;
    bus.calc_hit = 1'b0;
    bus.p0_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
